// File: rtl/ras_pkg.sv
// ras_pkg: shared types and widths for the RAS sequencing controller.
//   ras_ctrl_state_e : controller states (RUN / POP / FIX)
//   ras_ckpt_t       : checkpoint record {depth, top}
//   RAS_DEPTH_W      : width of the shadow depth counter
// The RAS entry count comes from the RAS_SIZE macro (default 8).
`ifndef RAS_SIZE
`define RAS_SIZE 8
`endif

package ras_pkg;

  localparam int RAS_SIZE_DEF = `RAS_SIZE;
  localparam int RAS_DEPTH_W  = $clog2(RAS_SIZE_DEF) + 1;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    POP = 2'd1,
    FIX = 2'd2
  } ras_ctrl_state_e;

  typedef struct packed {
    logic [RAS_DEPTH_W-1:0] depth;
    logic [31:0]            top;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if: fetch/RAS-side bus of the RAS controller.
//   master : fetch stage + RAS (drives flags, checkpoint/recover, RAS top)
//   slave  : ras_ctrl (drives RAS commands, prediction, fetch stall)
interface ras_ctrl_if #(
  parameter int NUM_CKPT = 4,
  parameter int TAG_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
);

  logic             if_valid;
  logic [31:0]      if_pc;
  logic             if_is_call;
  logic             if_is_return;
  logic             ckpt_save;
  logic [TAG_W-1:0] ckpt_tag;
  logic             recover_en;
  logic [TAG_W-1:0] recover_tag;
  logic [31:0]      ras_next_pc;
  logic             ras_valid;
  logic             ras_write_en;
  logic             ras_clear_en;
  logic [31:0]      ras_current_pc;
  logic             predict_valid;
  logic [31:0]      predict_pc;
  logic             fetch_stall;

  modport master (
    output if_valid, if_pc, if_is_call, if_is_return,
    output ckpt_save, ckpt_tag, recover_en, recover_tag,
    output ras_next_pc, ras_valid,
    input  ras_write_en, ras_clear_en, ras_current_pc,
    input  predict_valid, predict_pc, fetch_stall
  );

  modport slave (
    input  if_valid, if_pc, if_is_call, if_is_return,
    input  ckpt_save, ckpt_tag, recover_en, recover_tag,
    input  ras_next_pc, ras_valid,
    output ras_write_en, ras_clear_en, ras_current_pc,
    output predict_valid, predict_pc, fetch_stall
  );

endinterface

// File: rtl/ras_ckpt_file.sv
// ras_ckpt_file: NUM_CKPT x ras_ckpt_t checkpoint register file.
//   clock, reset : clock, async active-high reset (all slots cleared)
//   we/waddr/wdata : single write port, lands on the rising edge
//   raddr/rdata    : asynchronous read port
module ras_ckpt_file
  import ras_pkg::*;
#(
  parameter int NUM_CKPT = 4,
  parameter int TAG_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [TAG_W-1:0] waddr,
  input  ras_ckpt_t        wdata,
  input  logic [TAG_W-1:0] raddr,
  output ras_ckpt_t        rdata
);

  ras_ckpt_t mem [NUM_CKPT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ras_ctrl.sv
// ras_ctrl: return address stack sequencing controller.
//   Turns predecoded call/return flags into RAS push/pop/replace commands,
//   forwards the RAS top as return prediction, keeps a shadow depth and
//   per-branch checkpoints, and on recover_en replays pops plus one
//   replace/push so the RAS matches the checkpoint (fetch stalled meanwhile).
// Ports:
//   clock, reset : clock, async active-high reset
//   bus          : ras_ctrl_if.slave (fetch flags, checkpoint/recover,
//                  RAS top in; RAS commands, prediction, fetch_stall out)
//   stat_*       : 32-bit saturating event counters, only when
//                  RAS_CTRL_STATS_EN is defined
// Commands and predictions are combinational; state/depth are registered.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int RAS_SIZE = `RAS_SIZE,
  parameter int NUM_CKPT = 4
) (
  input  logic        clock,
  input  logic        reset,
  ras_ctrl_if.slave   bus
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [31:0] stat_push,
  output logic [31:0] stat_pop,
  output logic [31:0] stat_repair,
  output logic [31:0] stat_underflow
`endif
);

  localparam int TAG_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
  localparam logic [RAS_DEPTH_W-1:0] DEPTH_MAX = RAS_DEPTH_W'(RAS_SIZE - 1);

  ras_ctrl_state_e        state;
  logic [RAS_DEPTH_W-1:0] depth;
  logic [RAS_DEPTH_W-1:0] depth_next;
  logic [RAS_DEPTH_W-1:0] tgt_depth;
  logic [31:0]            tgt_top;

  logic        write_en;
  logic        clear_en;
  logic [31:0] current_pc;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        stall;
  logic        underflow;

  logic        ckpt_we;
  ras_ckpt_t   ckpt_wdata;
  ras_ckpt_t   ckpt_rdata;

  // Validity comes from the shadow depth, not the RAS's own flag.
  logic unused_ras_valid;
  assign unused_ras_valid = bus.ras_valid;

  ras_ckpt_file #(
    .NUM_CKPT (NUM_CKPT),
    .TAG_W    (TAG_W)
  ) u_ckpt (
    .clock (clock),
    .reset (reset),
    .we    (ckpt_we),
    .waddr (bus.ckpt_tag),
    .wdata (ckpt_wdata),
    .raddr (bus.recover_tag),
    .rdata (ckpt_rdata)
  );

  always_comb begin
    write_en   = 1'b0;
    clear_en   = 1'b0;
    current_pc = '0;
    pred_valid = 1'b0;
    pred_pc    = '0;
    depth_next = depth;
    ckpt_we    = 1'b0;
    underflow  = 1'b0;
    stall      = (state != RUN) | bus.recover_en;

    // recover_en overrides everything: no command this cycle.
    if (!bus.recover_en) begin
      unique case (state)
        RUN: begin
          ckpt_we = bus.ckpt_save;
          if (bus.if_valid) begin
            if (bus.if_is_call && bus.if_is_return) begin
              write_en   = 1'b1;
              clear_en   = 1'b1;
              current_pc = bus.if_pc;
              pred_valid = (depth != '0);
              pred_pc    = (depth != '0) ? bus.ras_next_pc : '0;
            end else if (bus.if_is_call) begin
              write_en   = 1'b1;
              current_pc = bus.if_pc;
              // RAS drops its oldest entry when full; depth saturates.
              if (depth != DEPTH_MAX) depth_next = depth + 1'b1;
            end else if (bus.if_is_return) begin
              if (depth != '0) begin
                clear_en   = 1'b1;
                pred_valid = 1'b1;
                pred_pc    = bus.ras_next_pc;
                depth_next = depth - 1'b1;
              end else begin
                underflow = 1'b1;
              end
            end
          end
        end
        POP: begin
          if (depth > tgt_depth) begin
            clear_en   = 1'b1;
            depth_next = depth - 1'b1;
          end
        end
        FIX: begin
          // RAS stores current_pc+4, so feed it the checkpointed top minus 4.
          if (depth == tgt_depth && tgt_depth != '0) begin
            write_en   = 1'b1;
            clear_en   = 1'b1;
            current_pc = tgt_top - 32'd4;
          end else if (depth < tgt_depth) begin
            write_en   = 1'b1;
            current_pc = tgt_top - 32'd4;
            depth_next = depth + 1'b1;
          end
        end
        default: ;
      endcase
    end

    ckpt_wdata.depth = depth_next;
    ckpt_wdata.top   = (bus.if_valid && bus.if_is_call) ? (bus.if_pc + 32'd4)
                                                        : bus.ras_next_pc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      depth     <= '0;
      tgt_depth <= '0;
      tgt_top   <= '0;
    end else begin
      depth <= depth_next;
      if (bus.recover_en) begin
        tgt_depth <= ckpt_rdata.depth;
        tgt_top   <= ckpt_rdata.top;
        state     <= POP;
      end else begin
        unique case (state)
          RUN:     state <= RUN;
          POP:     if (depth <= tgt_depth) state <= FIX;
          FIX:     state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

  assign bus.ras_write_en   = write_en;
  assign bus.ras_clear_en   = clear_en;
  assign bus.ras_current_pc = current_pc;
  assign bus.predict_valid  = pred_valid;
  assign bus.predict_pc     = pred_pc;
  assign bus.fetch_stall    = stall;

`ifdef RAS_CTRL_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_push      <= '0;
      stat_pop       <= '0;
      stat_repair    <= '0;
      stat_underflow <= '0;
    end else begin
      if (write_en && !clear_en && stat_push != '1)  stat_push <= stat_push + 1'b1;
      if (clear_en && !write_en && stat_pop != '1)   stat_pop  <= stat_pop + 1'b1;
      if (bus.recover_en && stat_repair != '1)       stat_repair <= stat_repair + 1'b1;
      if (underflow && stat_underflow != '1)         stat_underflow <= stat_underflow + 1'b1;
    end
  end
`else
  logic unused_underflow;
  assign unused_underflow = underflow;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: table-driven self-checking bench for ras_ctrl with a
// behavioural RAS (capacity RAS_SIZE-1, drops oldest when full) supplying
// ras_next_pc, and a scoreboard queue of expected outputs.
module tb_ras_ctrl;

  localparam int CAP = 7;

  logic clock;
  logic reset;

  ras_ctrl_if #(.NUM_CKPT(4)) bus ();

`ifdef RAS_CTRL_STATS_EN
  logic [31:0] stat_push, stat_pop, stat_repair, stat_underflow;
`endif

  ras_ctrl #(.RAS_SIZE(8), .NUM_CKPT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef RAS_CTRL_STATS_EN
    ,
    .stat_push      (stat_push),
    .stat_pop       (stat_pop),
    .stat_repair    (stat_repair),
    .stat_underflow (stat_underflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAS driven by the DUT's commands.
  logic [31:0] stk [CAP];
  int          cnt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 0;
    end else if (bus.ras_write_en && bus.ras_clear_en) begin
      if (cnt > 0) stk[cnt-1] <= bus.ras_current_pc + 32'd4;
    end else if (bus.ras_write_en) begin
      if (cnt == CAP) begin
        for (int i = 0; i < CAP - 1; i++) stk[i] <= stk[i+1];
        stk[CAP-1] <= bus.ras_current_pc + 32'd4;
      end else begin
        stk[cnt] <= bus.ras_current_pc + 32'd4;
        cnt      <= cnt + 1;
      end
    end else if (bus.ras_clear_en) begin
      if (cnt > 0) cnt <= cnt - 1;
    end
  end

  assign bus.ras_next_pc = (cnt > 0) ? stk[cnt-1] : 32'h0;
  assign bus.ras_valid   = (cnt > 0);

  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] pc;
    logic        c;
    logic        r;
    logic        sv;
    logic [1:0]  st;
    logic        rc;
    logic [1:0]  rt;
    logic        we;
    logic        ce;
    logic [31:0] cur;
    logic        pv;
    logic [31:0] ppc;
    logic        stl;
  } vec_t;

  vec_t tbl [$];
  vec_t exp_q [$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic vec_t mk(string nm, logic v, logic [31:0] pc, logic c,
                              logic r, logic sv, logic [1:0] st, logic rc,
                              logic [1:0] rt, logic we, logic ce,
                              logic [31:0] cur, logic pv, logic [31:0] ppc,
                              logic stl);
    vec_t x;
    x.nm = nm; x.v = v; x.pc = pc; x.c = c; x.r = r; x.sv = sv; x.st = st;
    x.rc = rc; x.rt = rt; x.we = we; x.ce = ce; x.cur = cur; x.pv = pv;
    x.ppc = ppc; x.stl = stl;
    return x;
  endfunction

  function automatic vec_t v_call(string nm, logic [31:0] pc);
    return mk(nm, 1, pc, 1, 0, 0, 0, 0, 0, 1, 0, pc, 0, 0, 0);
  endfunction
  function automatic vec_t v_call_save(string nm, logic [31:0] pc, logic [1:0] tag);
    return mk(nm, 1, pc, 1, 0, 1, tag, 0, 0, 1, 0, pc, 0, 0, 0);
  endfunction
  function automatic vec_t v_ret(string nm, logic [31:0] ppc);
    return mk(nm, 1, 32'h50, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, ppc, 0);
  endfunction
  function automatic vec_t v_ret_empty(string nm);
    return mk(nm, 1, 32'h50, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t v_both(string nm, logic [31:0] pc, logic pv, logic [31:0] ppc);
    return mk(nm, 1, pc, 1, 1, 0, 0, 0, 0, 1, 1, pc, pv, ppc, 0);
  endfunction
  function automatic vec_t v_idle(string nm);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t v_rec(string nm, logic [1:0] tag);
    return mk(nm, 0, 0, 0, 0, 0, 0, 1, tag, 0, 0, 0, 0, 0, 1);
  endfunction
  function automatic vec_t v_pop(string nm);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
  endfunction
  function automatic vec_t v_stall(string nm);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction
  function automatic vec_t v_fix_rep(string nm, logic [31:0] cur);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, cur, 0, 0, 1);
  endfunction
  function automatic vec_t v_fix_push(string nm, logic [31:0] cur);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, cur, 0, 0, 1);
  endfunction

  function automatic logic [67:0] outs();
    return {bus.ras_write_en, bus.ras_clear_en, bus.ras_current_pc,
            bus.predict_valid, bus.predict_pc, bus.fetch_stall};
  endfunction

  task automatic check(input string nm, input logic [67:0] act, input logic [67:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got {we,ce,cur,pv,ppc,stall}=%h expected %h", nm, act, exp);
  endtask

  task automatic drive_idle();
    bus.if_valid = 0; bus.if_pc = 0; bus.if_is_call = 0; bus.if_is_return = 0;
    bus.ckpt_save = 0; bus.ckpt_tag = 0; bus.recover_en = 0; bus.recover_tag = 0;
  endtask

  task automatic run_vec(input vec_t x);
    vec_t e;
    @(negedge clock);
    bus.if_valid = x.v; bus.if_pc = x.pc; bus.if_is_call = x.c;
    bus.if_is_return = x.r; bus.ckpt_save = x.sv; bus.ckpt_tag = x.st;
    bus.recover_en = x.rc; bus.recover_tag = x.rt;
    exp_q.push_back(x);
    #2;
    e = exp_q.pop_front();
    check(e.nm, outs(), {e.we, e.ce, e.cur, e.pv, e.ppc, e.stl});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Basic call/return ordering and empty return.
    tbl.push_back(v_idle("reset_idle"));
    tbl.push_back(v_call("call_100", 32'h100));
    tbl.push_back(v_call("call_200", 32'h200));
    tbl.push_back(v_call("call_300", 32'h300));
    tbl.push_back(v_ret("ret_304", 32'h304));
    tbl.push_back(v_ret("ret_204", 32'h204));
    tbl.push_back(v_ret("ret_104", 32'h104));
    tbl.push_back(v_ret_empty("ret_empty"));
    tbl.push_back(mk("invalid_call", 0, 32'h777, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Depth saturation at RAS_SIZE-1.
    for (int i = 0; i < 9; i++)
      tbl.push_back(v_call($sformatf("sat_call%0d", i), 32'h1000 + 32'(i) * 32'h10));
    for (int i = 8; i >= 2; i--)
      tbl.push_back(v_ret($sformatf("sat_ret%0d", i), 32'h1004 + 32'(i) * 32'h10));
    tbl.push_back(v_ret_empty("sat_ret_empty"));
    // Recover with two excess entries; fetch suppressed while stalled.
    tbl.push_back(v_call_save("rec1_call_save", 32'h100, 2'd1));
    tbl.push_back(v_call("rec1_call_200", 32'h200));
    tbl.push_back(v_call("rec1_call_300", 32'h300));
    tbl.push_back(v_rec("rec1_recover", 2'd1));
    tbl.push_back(mk("rec1_pop1_fetch_blocked", 1, 32'h999, 1, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v_pop("rec1_pop2"));
    tbl.push_back(v_stall("rec1_eval"));
    tbl.push_back(v_fix_rep("rec1_fix_replace", 32'h100));
    tbl.push_back(v_ret("rec1_ret_104", 32'h104));
    // Recover to a deeper checkpoint: single push.
    tbl.push_back(v_call("rec2_call_400", 32'h400));
    tbl.push_back(v_call_save("rec2_call_save", 32'h500, 2'd0));
    tbl.push_back(v_ret("rec2_ret_504", 32'h504));
    tbl.push_back(v_ret("rec2_ret_404", 32'h404));
    tbl.push_back(v_rec("rec2_recover", 2'd0));
    tbl.push_back(v_stall("rec2_eval"));
    tbl.push_back(v_fix_push("rec2_fix_push", 32'h500));
    tbl.push_back(v_ret("rec2_ret_504b", 32'h504));
    tbl.push_back(v_ret_empty("rec2_ret_empty"));
    // Recover restarted mid-POP with another tag.
    tbl.push_back(v_call_save("rec3_call_600", 32'h600, 2'd2));
    tbl.push_back(v_call_save("rec3_call_700", 32'h700, 2'd3));
    tbl.push_back(v_call("rec3_call_800", 32'h800));
    tbl.push_back(v_call("rec3_call_900", 32'h900));
    tbl.push_back(v_rec("rec3_recover_t2", 2'd2));
    tbl.push_back(v_pop("rec3_pop1"));
    tbl.push_back(v_rec("rec3_recover_t3", 2'd3));
    tbl.push_back(v_pop("rec3_pop2"));
    tbl.push_back(v_stall("rec3_eval"));
    tbl.push_back(v_fix_rep("rec3_fix_replace", 32'h700));
    tbl.push_back(v_ret("rec3_ret_704", 32'h704));
    tbl.push_back(v_ret("rec3_ret_604", 32'h604));
    tbl.push_back(v_ret_empty("rec3_ret_empty"));
    // Save then recover on the very next cycle reads the new slot data.
    tbl.push_back(v_call_save("rec4_call_save", 32'hC00, 2'd0));
    tbl.push_back(v_rec("rec4_recover", 2'd0));
    tbl.push_back(v_stall("rec4_eval"));
    tbl.push_back(v_fix_rep("rec4_fix_replace", 32'hC00));
    tbl.push_back(v_ret("rec4_ret_c04", 32'hC04));
    // Simultaneous call + return.
    tbl.push_back(v_call("both_call_a00", 32'hA00));
    tbl.push_back(v_both("both_replace", 32'hB00, 1'b1, 32'hA04));
    tbl.push_back(v_ret("both_ret_b04", 32'hB04));
    tbl.push_back(v_ret_empty("both_ret_empty"));
    tbl.push_back(v_both("both_at_empty", 32'hB10, 1'b0, 32'h0));

    drive_idle();
    reset = 1'b1;
    #1;
    check("reset_outputs", outs(), '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Asynchronous reset during a repair.
    run_vec(v_call("rst_call_d00", 32'hD00));
    run_vec(v_call("rst_call_e00", 32'hE00));
    run_vec(v_call("rst_call_f00", 32'hF00));
    run_vec(v_rec("rst_recover", 2'd1));
    run_vec(v_pop("rst_pop1"));
    #1;
    reset = 1'b1;
    #1;
    check("reset_async_outputs", outs(), '0);
    @(negedge clock);
    reset = 1'b0;
    run_vec(v_ret_empty("rst_depth0"));
    // Checkpoints cleared: recovery to slot 1 finds depth 0, FIX is a no-op.
    run_vec(v_rec("rst_ckpt_recover", 2'd1));
    run_vec(v_stall("rst_ckpt_eval"));
    run_vec(v_stall("rst_ckpt_fix_none"));
    run_vec(v_idle("rst_ckpt_run"));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
